// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the host-side run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CORE_RST,
    S_RUN,
    S_DRAIN_RD,
    S_DRAIN_OUT
  } run_state_t;

  // Cycles the core is held in reset between load and run.
  localparam int CORE_RST_HOLD = 2;

  localparam int DEF_AW       = 8;
  localparam int DEF_LD_BASE  = 0;
  localparam int DEF_RES_BASE = 64;
  localparam int DEF_RES_LEN  = 64;
  localparam int DEF_CW       = 16;
  localparam int DEF_MAX_CYC  = 'hFFFF;

endpackage

// File: rtl/run_ctrl.sv
// Host-side run controller: loads data memory, runs the core with a cycle
// limit, then streams a fixed result window back to the host.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int             AW       = DEF_AW,
  parameter int             LD_BASE  = DEF_LD_BASE,
  parameter int             RES_BASE = DEF_RES_BASE,
  parameter int             RES_LEN  = DEF_RES_LEN,
  parameter int             CW       = DEF_CW,
  parameter logic [CW-1:0]  MAX_CYC  = CW'(DEF_MAX_CYC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data,
  output logic          busy,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  localparam int            HW        = (CORE_RST_HOLD > 1) ? $clog2(CORE_RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(CORE_RST_HOLD - 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(RES_LEN - 1);
  localparam logic [AW-1:0] LD_ADDR0  = AW'(LD_BASE);
  localparam logic [AW-1:0] RES_ADDR0 = AW'(RES_BASE);

  run_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] ridx_q, ridx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic [7:0]    odata_q, odata_d;

  logic          core_reset_q, core_req_q, mem_sel_q, in_ready_q;
  logic          out_valid_q, out_last_q, busy_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ridx_d  = ridx_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    odata_d = odata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          cnt_d   = '0;
          to_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          idx_d = idx_q + 1'b1;
          if (in_last) begin
            state_d = S_CORE_RST;
            hold_d  = '0;
          end
        end
      end
      S_CORE_RST: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      S_RUN: begin
        // done has priority over the limit so a job finishing exactly on
        // the last allowed cycle is not reported as a timeout
        if (core_done) begin
          state_d = S_DRAIN_RD;
          ridx_d  = '0;
        end else if (cnt_q == MAX_CYC) begin
          to_d    = 1'b1;
          state_d = S_DRAIN_RD;
          ridx_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN_RD: begin
        odata_d = mem_rd_data;
        state_d = S_DRAIN_OUT;
      end
      S_DRAIN_OUT: begin
        if (out_ready) begin
          if (ridx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            ridx_d  = ridx_q + 1'b1;
            state_d = S_DRAIN_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      ridx_q       <= '0;
      hold_q       <= '0;
      cnt_q        <= '0;
      to_q         <= 1'b0;
      odata_q      <= '0;
      core_reset_q <= 1'b1;
      core_req_q   <= 1'b0;
      mem_sel_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ridx_q       <= ridx_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      odata_q      <= odata_d;
      // Status lines are decoded from the next state so they are clean flops.
      core_reset_q <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_CORE_RST);
      core_req_q   <= (state_d == S_RUN);
      mem_sel_q    <= (state_d == S_LOAD) || (state_d == S_DRAIN_RD);
      in_ready_q   <= (state_d == S_LOAD);
      out_valid_q  <= (state_d == S_DRAIN_OUT);
      out_last_q   <= (state_d == S_DRAIN_OUT) && (ridx_d == LAST_IDX);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    mem_addr = '0;
    if (state_q == S_LOAD)          mem_addr = LD_ADDR0 + idx_q;
    else if (state_q == S_DRAIN_RD) mem_addr = RES_ADDR0 + ridx_q;
  end

  assign mem_wr_en   = in_ready_q & in_valid;
  assign mem_wr_data = in_ready_q ? in_data : 8'h00;

  assign core_reset = core_reset_q;
  assign core_req   = core_req_q;
  assign mem_sel    = mem_sel_q;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = odata_q;
  assign busy       = busy_q;
  assign timeout    = to_q;
  assign cycle_cnt  = cnt_q;

  a_out_hold: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: vector table of jobs, random jobs against a simple
// job-level model, and reset-abort sequences.
module tb_run_ctrl;
  localparam int AW = 8, LDB = 254, RSB = 64, RL = 4, CW = 16, MAXC = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [7:0]    in_data, out_data, mem_wr_data, mem_rd_data;
  logic          core_reset, core_req, core_done, mem_sel, mem_wr_en, busy, timeout;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] cycle_cnt;

  run_ctrl #(.AW(AW), .LD_BASE(LDB), .RES_BASE(RSB), .RES_LEN(RL), .CW(CW),
             .MAX_CYC(16'(MAXC))) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
    .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .busy(busy), .timeout(timeout), .cycle_cnt(cycle_cnt));

  // Memory, write log and core model
  logic [7:0]  mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0, pre_data = '0;
  logic [15:0] wq[$];
  int          run_idx = 0;
  int          done_at = 1000;

  always @(posedge clk) begin
    if (mem_wr_en) begin
      wq.push_back({mem_addr, mem_wr_data});
      if (mem_sel) mem[mem_addr] <= mem_wr_data;
    end
    if (pre_we) mem[pre_addr] <= pre_data;
    run_idx <= core_req ? run_idx + 1 : 0;
  end
  assign core_done   = core_req && (run_idx == done_at);
  assign mem_rd_data = mem[mem_addr];

  int total = 0, bad = 0;
  logic [7:0] ld_data [8];
  logic [7:0] res_exp [RL];

  typedef struct {
    int len; int d_at; int stall_beat; int stall_len; int exp_cnt; bit exp_to;
  } vec_t;
  vec_t vt[6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_job(input int len, input int d_at, input int stall_beat,
                         input int stall_len, input int exp_cnt, input bit exp_to,
                         input bit rnd);
    int i, n, w, s;
    for (int k = 0; k < RL; k++) begin
      pre_we = 1'b1; pre_addr = 8'(RSB + k); pre_data = 8'($urandom);
      res_exp[k] = pre_data;
      tick();
    end
    pre_we = 1'b0;
    wq.delete();
    done_at = d_at;
    chk("idle_busy", busy, 0);
    chk("idle_core_reset", core_reset, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("load_in_ready", in_ready, 1);
    chk("load_mem_sel", mem_sel, 1);
    chk("start_clr_cnt", cycle_cnt, 0);
    chk("start_clr_to", timeout, 0);
    i = 0;
    while (i < len) begin
      if (rnd && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_last = 1'($urandom); in_data = 8'($urandom);
        tick();
      end else begin
        in_valid = 1'b1; in_data = ld_data[i]; in_last = (i == len - 1);
        tick(); i++;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("rst1_core_reset", core_reset, 1);
    chk("rst1_core_req", core_req, 0);
    chk("rst1_in_ready", in_ready, 0);
    tick();
    chk("rst2_core_reset", core_reset, 1);
    chk("rst2_core_req", core_req, 0);
    tick();
    chk("run_core_reset", core_reset, 0);
    chk("run_core_req", core_req, 1);
    chk("run_mem_sel", mem_sel, 0);
    n = 0;
    while (core_req && n < 200) begin n++; tick(); end
    chk("run_cycles", n, exp_cnt + 1);
    chk("wr_count", wq.size(), len);
    for (int j = 0; j < len && j < wq.size(); j++) begin
      chk("wr_addr", {24'd0, wq[j][15:8]}, 32'((LDB + j) % 256));
      chk("wr_data", {24'd0, wq[j][7:0]}, {24'd0, ld_data[j]});
    end
    for (int k = 0; k < RL; k++) begin
      w = 0;
      while (!out_valid && w < 10) begin w++; tick(); end
      chk("drain_gap", w, 1);
      chk("out_data", out_data, res_exp[k]);
      chk("out_last", out_last, (k == RL - 1));
      s = (k == stall_beat) ? stall_len : (rnd ? $urandom_range(0, 3) : 0);
      for (int j = 0; j < s; j++) begin
        out_ready = 1'b0;
        if (rnd) start = 1'($urandom);
        tick();
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, res_exp[k]);
      end
      start = 1'b0;
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    chk("end_busy", busy, 0);
    chk("end_out_valid", out_valid, 0);
    chk("end_cycle_cnt", cycle_cnt, exp_cnt);
    chk("end_timeout", timeout, exp_to);
    chk("end_core_reset", core_reset, 1);
  endtask

  task automatic reset_mid(input bit in_drain);
    int n;
    wq.delete();
    done_at = in_drain ? 0 : 1000;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    if (in_drain) begin
      n = 0;
      while (!out_valid && n < 20) begin n++; tick(); end
      chk("rm_reach_drain", out_valid, 1);
    end else begin
      tick(); tick(); tick();
      chk("rm_reach_run", core_req, 1);
    end
    out_ready = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rm_core_reset", core_reset, 1);
    chk("rm_out_valid", out_valid, 0);
    chk("rm_core_req", core_req, 0);
    chk("rm_busy", busy, 0);
    chk("rm_cycle_cnt", cycle_cnt, 0);
    chk("rm_timeout", timeout, 0);
    tick(); tick();
    chk("rm_stay_idle", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, d;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0;
    tick(); tick();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_core_req", core_req, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_sel", mem_sel, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    reset = 1'b0;
    tick();

    // load beats while idle must not write
    wq.delete();
    in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
    #1 chk("idle_no_wr_en", mem_wr_en, 0);
    tick(); tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("idle_no_write", wq.size(), 0);
    chk("idle_still", busy, 0);

    //          len  done  stall_beat stall_len exp_cnt exp_to
    vt[0] = '{3,   10,   -1,        0,        10,     1'b0};
    vt[1] = '{4,   1000, -1,        0,        12,     1'b1};
    vt[2] = '{2,   12,   -1,        0,        12,     1'b0};
    vt[3] = '{4,   0,    -1,        0,        0,      1'b0};
    vt[4] = '{2,   5,    1,         7,        5,      1'b0};
    vt[5] = '{1,   13,   0,         3,        12,     1'b1};
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 8; i++) ld_data[i] = 8'(8'h11 * (i + 1));
      run_job(vt[v].len, vt[v].d_at, vt[v].stall_beat, vt[v].stall_len,
              vt[v].exp_cnt, vt[v].exp_to, 1'b0);
    end

    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(1, 6);
      d   = $urandom_range(0, 16);
      for (int i = 0; i < 8; i++) ld_data[i] = 8'($urandom);
      run_job(len, d, -1, 0, (d <= MAXC) ? d : MAXC, (d > MAXC), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
